// File: rtl/nor_equiv_checker.sv
// nor_equiv_checker: clocked sweeper/checker for two NOR implementations.
// Drives every input vector onto x_out and compares both DUT outputs against
// a golden NOR. It counts mismatching vectors, records the first failing
// vector and reports pass/fail.
// Optional feature macro: FAIL_STOP_EN. When defined, the sweep stops at the
// first mismatching vector and x_out stays frozen on it.
module nor_equiv_checker #(
    parameter int unsigned N_IN   = 2,
    parameter int          SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  x_out,
    input  logic             a_in,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [N_IN-1:0]  fail_vec,
    output logic             fail_valid
);

    // A hold time below one cycle is clamped to one cycle.
    localparam int unsigned SETTLE_EFF = (SETTLE < 1) ? 32'd1 : 32'(SETTLE);
    localparam int unsigned CW         = $clog2(SETTLE_EFF + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  fvec_q, fvec_d;
    logic             fval_q, fval_d;

    logic             golden;
    logic             mismatch;
    logic             last_vec;
    logic [CNT_W-1:0] err_inc;

    // Golden reference and compare results for the vector currently on x_out.
    always_comb begin
        golden   = ~|vec_q;
        mismatch = (a_in != golden) | (b_in != golden);
        last_vec = (vec_q == {N_IN{1'b1}});
        err_inc  = (err_q == {CNT_W{1'b1}}) ? err_q : err_q + CNT_W'(1);
    end

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        fval_d  = fval_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d   = '0;
                    cnt_d   = CW'(SETTLE_EFF);
                    err_d   = '0;
                    pass_d  = 1'b0;
                    fval_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_inc;
                    if (!fval_q) begin
                        fvec_d = vec_q;
                        fval_d = 1'b1;
                    end
                end
`ifdef FAIL_STOP_EN
                if (last_vec || mismatch) begin
`else
                if (last_vec) begin
`endif
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = CW'(SETTLE_EFF);
                    state_d = ST_HOLD;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
            fval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            fval_q  <= fval_d;
        end
    end

    assign x_out      = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fval_q;

endmodule

// File: tb/tb_nor_equiv_checker.sv
// tb_nor_equiv_checker: directed sweeps of nor_equiv_checker with stub DUTs of
// several fault modes; expected sweep results are queued when a sweep is
// started and popped when done is seen.
module tb_nor_equiv_checker;

    localparam int unsigned N_IN   = 2;
    localparam int          SETTLE = 1;
    localparam int unsigned CNT_W  = 8;

    // Stub DUT behaviours.
    localparam int M_GOOD   = 0;
    localparam int M_B_ZERO = 1;
    localparam int M_A_ONE  = 2;
    localparam int M_AND    = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [N_IN-1:0]  x_out;
    logic             a_in;
    logic             b_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [N_IN-1:0]  fail_vec;
    logic             fail_valid;

    int mode;
    int checks;
    int errors;

    typedef struct {
        int         lat;
        logic       pass;
        int         err;
        logic [1:0] fvec;
        logic       fval;
        logic [1:0] xo;
    } exp_t;

    exp_t sb[$];

    nor_equiv_checker #(
        .N_IN  (N_IN),
        .SETTLE(SETTLE),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_out     (x_out),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec),
        .fail_valid(fail_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic stub_a(int m, logic [1:0] v);
        case (m)
            M_A_ONE: return 1'b1;
            M_AND:   return v[1] & v[0];
            default: return ~(v[1] | v[0]);
        endcase
    endfunction

    function automatic logic stub_b(int m, logic [1:0] v);
        case (m)
            M_B_ZERO: return 1'b0;
            M_AND:    return v[1] & v[0];
            default:  return ~(v[1] | v[0]);
        endcase
    endfunction

    // Combinational stub DUTs driven by the checker's vector.
    always_comb begin
        a_in = stub_a(mode, x_out);
        b_in = stub_b(mode, x_out);
    end

    // Reference sweep: NOR truth table per vector, stop rules, latency.
    function automatic exp_t model(int m);
        exp_t e;
        logic stop;
        logic g;
        logic [1:0] v;
        e.lat = 0; e.err = 0; e.fvec = 2'b00; e.fval = 1'b0; e.xo = 2'b00;
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!stop) begin
                v = 2'(i);
                e.lat = e.lat + SETTLE + 1;
                e.xo = v;
                g = (v == 2'b00);
                if (stub_a(m, v) != g || stub_b(m, v) != g) begin
                    e.err = e.err + 1;
                    if (!e.fval) begin
                        e.fvec = v;
                        e.fval = 1'b1;
                    end
`ifdef FAIL_STOP_EN
                    stop = 1'b1;
`endif
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x_out"}, 32'(x_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_fvec"}, 32'(fail_vec), 32'd0);
        check({tag, "_fval"}, 32'(fail_valid), 32'd0);
    endtask

    // Full sweep: optional start re-pulses at cycles 2 and 5 and in DONE.
    task automatic run_sweep(input string tag, input int m, input bit inject);
        exp_t e;
        int n;
        bit seen;
        bit extra;
        mode = m;
        sb.push_back(model(m));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            start = inject && (n == 1 || n == 4);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(e.lat));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'(e.pass));
        check({tag, "_err"}, 32'(err_count), 32'(e.err));
        check({tag, "_fval"}, 32'(fail_valid), 32'(e.fval));
        if (e.fval) check({tag, "_fvec"}, 32'(fail_vec), 32'(e.fvec));
        check({tag, "_x_out"}, 32'(x_out), 32'(e.xo));
        if (inject) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (busy || done) extra = 1'b1;
        end
        check({tag, "_no_second_sweep"}, 32'(extra), 32'd0);
        check({tag, "_pass_held"}, 32'(pass), 32'(e.pass));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mode   = M_GOOD;
        start  = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep("good", M_GOOD, 1'b0);
        run_sweep("b_zero", M_B_ZERO, 1'b0);
        run_sweep("a_one", M_A_ONE, 1'b0);
        run_sweep("and", M_AND, 1'b0);

        // Reset while vector 10 is in HOLD of a failing sweep.
        mode = M_A_ONE;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_x_out_before_rst", 32'(x_out), 32'd2);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep("after_rst", M_GOOD, 1'b0);
        run_sweep("repulse", M_GOOD, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nor_equiv_checker.md
Name: nor_equiv_checker

Overview:
- Sequential sweeper/checker that sits around the two-input NOR stages (gate-level and expression forms).
- Upstream role: drives every input combination onto the shared DUT inputs.
- Downstream role: samples both DUT outputs, compares each against an internal golden NOR, counts mismatches and reports pass/fail.
- Replaces hand-written stimulus sequences with a clocked, self-checking sweep.

Parameters:
- N_IN, 2: number of DUT inputs; sweep covers 2^N_IN vectors.
- SETTLE, 1: cycles each vector is held before sampling; values below 1 are treated as 1.
- CNT_W, 8: width of the mismatch counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- x_out  output  N_IN  vector driven to both DUTs; bit 0 = y, bit 1 = x when N_IN=2.
- a_in  input  1  output of DUT A.
- b_in  input  1  output of DUT B.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  high when the last sweep had zero mismatches; held until the next start.
- err_count  output  CNT_W  number of mismatching vectors; saturating.
- fail_vec  output  N_IN  first failing vector.
- fail_valid  output  1  fail_vec holds a valid value.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values (applied immediately, including mid-sweep):
  - state=IDLE, internal vector vec=0, x_out=0.
  - busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0.
- Golden reference: golden = ~|x_out (NOR of all bits).
- IDLE:
  - On start=1 at an edge: vec=0, x_out=0, settle counter=SETTLE.
  - Clear err_count, pass, fail_valid; busy=1; go to HOLD.
- HOLD: counter decrements each edge; at the edge where it reaches 0, go to SAMPLE.
- SAMPLE (one edge):
  - Mismatch = (a_in!=golden) | (b_in!=golden).
  - On mismatch: err_count+1, counted once per vector even if both outputs are wrong; saturates at 2^CNT_W-1.
  - On the first mismatch of a sweep: fail_vec=x_out, fail_valid=1.
  - If vec is all-ones, go to DONE.
  - Otherwise vec+1, x_out=vec+1, counter reloads SETTLE, go to HOLD.
- DONE (one cycle):
  - done=1, busy=0, pass=(err_count==0), then return to IDLE.
  - x_out keeps the last vector until the next start.
- Latency: done is high in the cycle after edge k+2^N_IN*(SETTLE+1), where k is the edge that captured start. For defaults this is 8 cycles.
- start while busy or in DONE is ignored; no queueing.
- DUT outputs are treated as combinational. They are sampled only in SAMPLE and ignored elsewhere.
- No wrap-around of vec inside a sweep; the sweep ends at all-ones.

Optional Feature:
- Macro FAIL_STOP_EN.
- Defined: at the first mismatch, SAMPLE goes directly to DONE.
  - x_out stays frozen at the failing vector for debug.
  - err_count=1, pass=0; done pulses early.
- Undefined: the full sweep always completes and every mismatching vector is counted.

Test Plan:
- Both DUTs correct NOR, defaults: start pulse -> done at 8 cycles, pass=1, err_count=0, fail_valid=0, x_out=11.
- b_in tied 0 -> only vector 00 fails: err_count=1, fail_vec=00, fail_valid=1, pass=0.
- a_in tied 1 -> vectors 01, 10, 11 fail: err_count=3, fail_vec=01, pass=0. With FAIL_STOP_EN: done after 4 cycles, x_out=01, err_count=1.
- a_in=b_in=AND of inputs -> vectors 00 and 11 fail: err_count=2, fail_vec=00. Both wrong at the same vector still counts as 1 per vector.
- rst_n low during HOLD of vector 10 -> all outputs reset in the same cycle. A fresh start then yields a full 8-cycle sweep with pass=1 on correct DUTs.
- start re-pulsed at cycles 2 and 5 of a sweep -> ignored; done timing unchanged; no second sweep. start during the DONE cycle is also ignored.
